// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter.
// Handshake: a word is taken at a rising edge where in_valid and in_ready are
// both high; in_ready is only high in IDLE, so the producer must hold in_data
// stable while in_valid is high and it has not yet seen that edge.
// Frames go out one bit per clock with start/last strobes, followed by a
// fixed idle gap. Every output is a flop; nothing combinational reaches a port.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             frame_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_END  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n, nxt_cnt, nxt_idx;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic             ready_n, sout_n, fv_n, fs_n, fl_n, busy_n;

    assign state_dbg = state;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so the registers below present them on the following cycle.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        ready_n   = in_ready;
        sout_n    = serial_out;
        fv_n      = frame_valid;
        fs_n      = 1'b0;
        fl_n      = 1'b0;
        busy_n    = busy;
        nxt_cnt   = bit_cnt + CW'(1);
        // The captured word is never shifted; the bit to send is selected by index.
        nxt_idx   = MSB_FIRST ? (LAST_BIT - nxt_cnt) : nxt_cnt;
        case (state)
            S_IDLE: begin
                sout_n  = IDLE_LEVEL;
                fv_n    = 1'b0;
                busy_n  = 1'b0;
                ready_n = 1'b1;
                if (in_valid && in_ready) begin
                    state_n   = S_SHIFT;
                    shreg_n   = in_data;
                    bit_cnt_n = '0;
                    sout_n    = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
                    fv_n      = 1'b1;
                    fs_n      = 1'b1;
                    ready_n   = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            S_SHIFT: begin
                ready_n = 1'b0;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_n = '0;
                    gap_cnt_n = '0;
                    sout_n    = IDLE_LEVEL;
                    fv_n      = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_n = S_GAP;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        ready_n = 1'b1;
                    end
                end else begin
                    bit_cnt_n = nxt_cnt;
                    sout_n    = shreg[nxt_idx];
                    fv_n      = 1'b1;
                    fl_n      = (nxt_cnt == LAST_BIT);
                    busy_n    = 1'b1;
                end
            end
            S_GAP: begin
                sout_n  = IDLE_LEVEL;
                fv_n    = 1'b0;
                ready_n = 1'b0;
                busy_n  = 1'b1;
                if (gap_cnt == GAP_END) begin
                    state_n   = S_IDLE;
                    gap_cnt_n = '0;
                    ready_n   = 1'b1;
                    busy_n    = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                sout_n  = IDLE_LEVEL;
                fv_n    = 1'b0;
                ready_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            in_ready    <= 1'b0;
            serial_out  <= IDLE_LEVEL;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            gap_cnt     <= gap_cnt_n;
            in_ready    <= ready_n;
            serial_out  <= sout_n;
            frame_valid <= fv_n;
            frame_start <= fs_n;
            frame_last  <= fl_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations share one clock and reset.
//   u0: MSB first, 1 gap cycle, idle level 0
//   u1: LSB first, no gap,      idle level 1
//   u2: MSB first, 3 gap cycles, idle level 0
// Expected serial bits come from a per-word queue built from the word value
// and the configured bit order; timing is checked against WIDTH and the gap.
module tb_piso_serializer;

    localparam int W  = 8;
    localparam int NI = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NI-1:0][W-1:0]  in_data;
    logic [NI-1:0]         in_valid;
    logic [NI-1:0]         in_ready;
    logic [NI-1:0]         serial_out;
    logic [NI-1:0]         frame_valid;
    logic [NI-1:0]         frame_start;
    logic [NI-1:0]         frame_last;
    logic [NI-1:0]         busy;
    logic [NI-1:0][1:0]    state_dbg;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   last_accept [NI];
    logic exp_q [$];

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .serial_out(serial_out[0]), .frame_valid(frame_valid[0]),
        .frame_start(frame_start[0]), .frame_last(frame_last[0]), .busy(busy[0]),
        .state_dbg(state_dbg[0]));

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .serial_out(serial_out[1]), .frame_valid(frame_valid[1]),
        .frame_start(frame_start[1]), .frame_last(frame_last[1]), .busy(busy[1]),
        .state_dbg(state_dbg[1]));

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .serial_out(serial_out[2]), .frame_valid(frame_valid[2]),
        .frame_start(frame_start[2]), .frame_last(frame_last[2]), .busy(busy[2]),
        .state_dbg(state_dbg[2]));

    function automatic bit msb_of(input int idx);
        return (idx != 1);
    endfunction

    function automatic int gap_of(input int idx);
        case (idx)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic idle_of(input int idx);
        return (idx == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the bit sequence a word must produce on the line.
    task automatic build_exp(input int idx, input logic [W-1:0] word);
        for (int i = 0; i < W; i++)
            exp_q.push_back(msb_of(idx) ? word[W-1-i] : word[i]);
    endtask

    task automatic chk_idle_line(input int idx, input string tag);
        chk({tag, "_sout"}, serial_out[idx], idle_of(idx));
        chk({tag, "_fv"},   frame_valid[idx], 1'b0);
        chk({tag, "_fs"},   frame_start[idx], 1'b0);
        chk({tag, "_fl"},   frame_last[idx], 1'b0);
    endtask

    // Sends one word and checks every cycle through the gap back to IDLE.
    // Entered and left just after a falling edge.
    task automatic send(input int idx, input logic [W-1:0] word, input bit keep_valid,
                        input bit disturb, input bit check_rate);
        int   wait_n;
        int   acc;
        logic b;
        build_exp(idx, word);
        in_data[idx]  = word;
        in_valid[idx] = 1'b1;
        wait_n = 0;
        while (!in_ready[idx] && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready[idx]) begin
            chk($sformatf("u%0d_ready_timeout", idx), 0, 1);
            exp_q.delete();
            in_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (check_rate)
            chk($sformatf("u%0d_accept_spacing", idx), acc - last_accept[idx], W + gap_of(idx) + 1);
        last_accept[idx] = acc;
        if (!keep_valid) in_valid[idx] = 1'b0;
        if (disturb)     in_data[idx]  = '0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            b = exp_q.pop_front();
            chk($sformatf("u%0d_bit%0d", idx, k),   serial_out[idx], b);
            chk($sformatf("u%0d_fv%0d", idx, k),    frame_valid[idx], 1'b1);
            chk($sformatf("u%0d_fs%0d", idx, k),    frame_start[idx], (k == 0));
            chk($sformatf("u%0d_fl%0d", idx, k),    frame_last[idx], (k == W - 1));
            chk($sformatf("u%0d_rdy%0d", idx, k),   in_ready[idx], 1'b0);
            chk($sformatf("u%0d_busy%0d", idx, k),  busy[idx], 1'b1);
            if (disturb) in_valid[idx] = (k == W - 1) ? 1'b0 : ~in_valid[idx];
        end
        for (int g = 0; g < gap_of(idx); g++) begin
            @(negedge clk);
            chk_idle_line(idx, $sformatf("u%0d_gap%0d", idx, g));
            chk($sformatf("u%0d_gap%0d_busy", idx, g), busy[idx], 1'b1);
            chk($sformatf("u%0d_gap%0d_rdy", idx, g),  in_ready[idx], 1'b0);
        end
        @(negedge clk);
        chk_idle_line(idx, $sformatf("u%0d_done", idx));
        chk($sformatf("u%0d_done_rdy", idx),  in_ready[idx], 1'b1);
        chk($sformatf("u%0d_done_busy", idx), busy[idx], 1'b0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence followed by randomized traffic.
    initial begin
        logic [W-1:0] w;
        bit           keep, prev_keep;
        int           dly;

        rst      = 1'b1;
        in_valid = '0;
        in_data  = '0;
        for (int i = 0; i < NI; i++) last_accept[i] = 0;

        // Reset values.
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk_idle_line(i, $sformatf("u%0d_rst", i));
            chk($sformatf("u%0d_rst_rdy", i),  in_ready[i], 1'b0);
            chk($sformatf("u%0d_rst_busy", i), busy[i], 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("u0_rel_rdy_before_edge", in_ready[0], 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d_rel_rdy_first_edge", i), in_ready[i], 1'b1);
        @(negedge clk);

        // Basic MSB-first and LSB-first frames.
        send(0, 8'hC1, 1'b0, 1'b0, 1'b0);
        send(1, 8'hC1, 1'b0, 1'b0, 1'b0);

        // Streaming with in_valid held high.
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        send(0, 8'h3C, 1'b1, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send(1, 8'hA5, 1'b1, 1'b0, 1'b0);
        send(1, 8'h3C, 1'b1, 1'b0, 1'b1);
        send(1, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Inputs disturbed during SHIFT must not affect the frame.
        send(0, 8'h96, 1'b0, 1'b1, 1'b0);

        // Idle level 1 with an all-zero word.
        send(1, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame, between clock edges.
        build_exp(0, 8'hF0);
        in_data[0]  = 8'hF0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("u0_abort_bit%0d", k), serial_out[0], exp_q.pop_front());
            chk($sformatf("u0_abort_fv%0d", k),  frame_valid[0], 1'b1);
        end
        exp_q.delete();
        #2;
        rst = 1'b1;
        #1;
        chk_idle_line(0, "u0_abort");
        chk("u0_abort_rdy",  in_ready[0], 1'b0);
        chk("u0_abort_busy", busy[0], 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("u0_abort_hold_fl", frame_last[0], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("u0_abort_rel_rdy", in_ready[0], 1'b1);
        chk("u0_abort_rel_fl",  frame_last[0], 1'b0);
        @(negedge clk);
        send(0, 8'h81, 1'b0, 1'b0, 1'b0);

        // Randomized words, idle delays and streaming bursts on every unit.
        for (int i = 0; i < NI; i++) begin
            prev_keep = 1'b0;
            for (int j = 0; j < 12; j++) begin
                if (!prev_keep) begin
                    dly = $urandom_range(0, 3);
                    for (int d = 0; d < dly; d++) begin
                        @(negedge clk);
                        chk_idle_line(i, $sformatf("u%0d_rnd_idle", i));
                        chk($sformatf("u%0d_rnd_idle_rdy", i), in_ready[i], 1'b1);
                    end
                end
                w    = W'($urandom);
                keep = (j == 11) ? 1'b0 : 1'($urandom_range(0, 1));
                send(i, w, keep, 1'b0, prev_keep);
                prev_keep = keep;
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the single-bit serial link that our serial shift registers carry.
- It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock. It marks the first and last bits of each frame with strobes.
- It inserts a programmable idle gap between frames.
- It sits between a parallel producer (a register or FIFO) and a serial line or serial shift-register chain.

Parameters:
- WIDTH, 8: word width in bits. Legal range is 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- GAP_CYCLES, 1: number of idle cycles after each frame's last bit before the next word can be accepted. Legal range is 0 or more.
- IDLE_LEVEL, 0: value driven on serial_out when no frame is active.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word to send.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial data, one bit per cycle.
- frame_valid  output  1  serial_out carries a data bit this cycle.
- frame_start  output  1  high on the first bit of a frame.
- frame_last  output  1  high on the last bit of a frame.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset values, applied asynchronously while rst is high:
  - state=IDLE, in_ready=0, serial_out=IDLE_LEVEL.
  - frame_valid=0, frame_start=0, frame_last=0, busy=0.
  - shift register=0, bit counter=0, gap counter=0.
- After rst is released, in_ready rises at the first clock edge.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, serial_out=IDLE_LEVEL, frame_valid=0.
  - Handshake is in_valid and in_ready sampled high at the same edge. On a handshake, in_data is captured into the shift register and the block moves to SHIFT.
  - No handshake: stay in IDLE.
- SHIFT:
  - The first bit appears on serial_out in the cycle right after the accepting edge, with frame_valid=1 and frame_start=1.
  - One bit is sent per cycle for WIDTH cycles. Bit order is set by MSB_FIRST.
  - frame_last=1 on the WIDTH-th bit. in_ready=0 throughout.
  - Changes on in_data or in_valid during SHIFT are ignored. The captured word is never modified.
- End of SHIFT, at the edge that ends the last bit:
  - If GAP_CYCLES>0: go to GAP.
  - If GAP_CYCLES=0: go to IDLE.
- GAP:
  - serial_out=IDLE_LEVEL, frame_valid=0, busy=1, in_ready=0.
  - Lasts exactly GAP_CYCLES cycles, then goes to IDLE.
- Throughput with in_valid held high: one accepting edge every WIDTH+GAP_CYCLES+1 cycles. There is no back-to-back acceptance during SHIFT.
- Strobe rules:
  - frame_start and frame_last are single-cycle pulses and only occur while frame_valid=1.
  - They are never high in the same cycle, because WIDTH is at least 2.
- Bit counter: range 0..WIDTH-1, width $clog2(WIDTH). It wraps to 0 when a frame completes.
- Gap counter: width $clog2(GAP_CYCLES+1), minimum 1 bit.
- Reset in the middle of a frame:
  - The frame is aborted immediately, with no partial completion.
  - serial_out returns to IDLE_LEVEL and all strobes drop at once.
  - No frame_last is produced for the aborted frame.
- in_valid dropping before acceptance is legal. No word is captured.

Test Plan:
- Basic MSB-first send (WIDTH=8, MSB_FIRST=1, GAP_CYCLES=1): present in_data=8'hC1 with in_valid=1.
  - Required: serial_out = 1,1,0,0,0,0,0,1 on the 8 cycles after the accepting edge.
  - frame_start on bit 1 only, frame_last on bit 8 only, frame_valid high for exactly 8 cycles.
  - Then 1 gap cycle with serial_out=0, then in_ready=1.
- LSB-first send (MSB_FIRST=0): in_data=8'hC1.
  - Required: serial_out = 1,0,0,0,0,0,1,1 with the same strobe timing as the MSB-first case.
- Streaming: hold in_valid=1 and send 8'hA5, 8'h3C, 8'hFF.
  - GAP_CYCLES=1: accepting edges exactly 10 cycles apart.
  - GAP_CYCLES=0: accepting edges exactly 9 cycles apart.
  - All 24 bits must be correct in order.
- Input stability: after 8'h96 is accepted, change in_data to 8'h00 and toggle in_valid during SHIFT.
  - Required: serial_out is still 1,0,0,1,0,1,1,0 and in_ready stays 0 until IDLE.
- Reset mid-frame: assert rst during bit 4 of 8'hF0, asynchronously between edges.
  - Required: serial_out=IDLE_LEVEL, frame_valid=0, in_ready=0 and busy=0 before the next edge, with no frame_last.
  - After release, in_ready=1 at the first edge, and a new 8'h81 transmits correctly.
- IDLE_LEVEL=1: while idle and in the gap, serial_out=1.
  - Data bits of 8'h00 are all 0 and delimited only by frame_valid.
